// File: rtl/bufft_reg_writer_if.sv
// Port bundle for the buffer-timestamp stream-to-register writer.
// The writer is the master of the register write port, so it uses the master modport.
interface bufft_reg_writer_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int STREAM_WIDTH = 64,
  parameter int ADDR_WIDTH   = 8
);
  logic [STREAM_WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic                    wr_req;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_ack;
  logic                    ps_consumed;
  logic                    busy;

  modport master (
    input  s_data, s_valid, wr_ack, ps_consumed,
    output s_ready, wr_req, wr_addr, wr_data, busy
  );

  modport slave (
    output s_data, s_valid, wr_ack, ps_consumed,
    input  s_ready, wr_req, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/bufft_reg_writer.sv
// Splits one bufft stream beat into register words, writes them plus a fresh flag,
// then blocks further beats until the PS reports it has consumed the registers.
//
// state      | meaning
// IDLE       | s_ready high, waiting for a beat
// WRITE      | writing data words BASE_ID .. BASE_ID+NUM_WORDS-1
// FLAG       | writing 1 to the fresh-flag register
// WAIT_PS    | holding off beats until ps_consumed
module bufft_reg_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int STREAM_WIDTH = 64,
  parameter int ADDR_WIDTH   = 8,
  parameter int BASE_ID      = 0
) (
  input logic clk,
  input logic rst,
  bufft_reg_writer_if.master bus
);
  localparam int NUM_WORDS = (STREAM_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int PAD_WIDTH = NUM_WORDS * DATA_WIDTH;
  localparam int CNT_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_FLAG    = 2'd2;
  localparam logic [1:0] ST_WAIT_PS = 2'd3;

  logic [1:0]           state;
  logic [PAD_WIDTH-1:0] pending;
  logic [CNT_WIDTH-1:0] words_left;
  logic [PAD_WIDTH-1:0] beat_padded;

  // Zero-extension fills the unused top of the last word.
  assign beat_padded = PAD_WIDTH'(bus.s_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= '0;
      words_left  <= '0;
      bus.s_ready <= 1'b0;
      bus.wr_req  <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.s_ready && bus.s_valid) begin
            state       <= ST_WRITE;
            bus.s_ready <= 1'b0;
            bus.busy    <= 1'b1;
            bus.wr_req  <= 1'b1;
            bus.wr_addr <= ADDR_WIDTH'(BASE_ID);
            bus.wr_data <= beat_padded[DATA_WIDTH-1:0];
            pending     <= beat_padded >> DATA_WIDTH;
            words_left  <= CNT_WIDTH'(NUM_WORDS - 1);
          end else begin
            bus.s_ready <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (bus.wr_ack) begin
            // The flag register directly follows the last data word.
            bus.wr_addr <= bus.wr_addr + ADDR_WIDTH'(1);
            if (words_left == '0) begin
              state       <= ST_FLAG;
              bus.wr_data <= DATA_WIDTH'(1);
            end else begin
              bus.wr_data <= pending[DATA_WIDTH-1:0];
              pending     <= pending >> DATA_WIDTH;
              words_left  <= words_left - CNT_WIDTH'(1);
            end
          end
        end
        ST_FLAG: begin
          if (bus.wr_ack) begin
            state      <= ST_WAIT_PS;
            bus.wr_req <= 1'b0;
          end
        end
        ST_WAIT_PS: begin
          if (bus.ps_consumed) begin
            state       <= ST_IDLE;
            bus.s_ready <= 1'b1;
            bus.busy    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bufft_reg_writer.sv
// Directed bench for bufft_reg_writer with DATA_WIDTH=32, STREAM_WIDTH=48, BASE_ID=0x10.
module tb_bufft_reg_writer;
  localparam int DW   = 32;
  localparam int SW   = 48;
  localparam int AW   = 8;
  localparam int BASE = 'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bufft_reg_writer_if #(.DATA_WIDTH(DW), .STREAM_WIDTH(SW), .ADDR_WIDTH(AW)) bus ();

  bufft_reg_writer #(
    .DATA_WIDTH(DW), .STREAM_WIDTH(SW), .ADDR_WIDTH(AW), .BASE_ID(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [SW-1:0] beat;
    int            dmax;
    logic [DW-1:0] w0;
    logic [DW-1:0] w1;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents a beat, waits (bounded) for s_ready, and checks the acceptance edge.
  task automatic accept_beat(input logic [SW-1:0] data);
    int n;
    bus.s_data  = data;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_before_accept", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_data  = ~data;
    chk("accept_wr_req", 64'(bus.wr_req), 64'd1);
    chk("accept_busy", 64'(bus.busy), 64'd1);
    chk("accept_s_ready", 64'(bus.s_ready), 64'd0);
  endtask

  // Acknowledges the two data words and the flag, each after 0..dmax idle cycles.
  task automatic run_writes(input int dmax, input logic [DW-1:0] w0, input logic [DW-1:0] w1);
    logic [DW-1:0] exp_d [3];
    int delay;
    exp_d[0] = w0;
    exp_d[1] = w1;
    exp_d[2] = 32'd1;
    for (int w = 0; w < 3; w++) begin
      delay = (dmax > 0) ? int'($urandom_range(dmax, 0)) : 0;
      for (int d = 0; d < delay; d++) begin
        bus.wr_ack = 1'b0;
        chk("pending_wr_req", 64'(bus.wr_req), 64'd1);
        chk("pending_wr_addr", 64'(bus.wr_addr), 64'(BASE + w));
        chk("pending_wr_data", 64'(bus.wr_data), 64'(exp_d[w]));
        @(negedge clk);
      end
      bus.wr_ack = 1'b1;
      chk("write_wr_req", 64'(bus.wr_req), 64'd1);
      chk("write_wr_addr", 64'(bus.wr_addr), 64'(BASE + w));
      chk("write_wr_data", 64'(bus.wr_data), 64'(exp_d[w]));
      @(negedge clk);
      bus.wr_ack = 1'b0;
    end
    chk("after_flag_wr_req", 64'(bus.wr_req), 64'd0);
    chk("after_flag_busy", 64'(bus.busy), 64'd1);
    chk("after_flag_s_ready", 64'(bus.s_ready), 64'd0);
  endtask

  task automatic finish_ps();
    repeat (2) @(negedge clk);
    chk("wait_ps_s_ready", 64'(bus.s_ready), 64'd0);
    bus.ps_consumed = 1'b1;
    @(negedge clk);
    bus.ps_consumed = 1'b0;
    chk("ps_s_ready", 64'(bus.s_ready), 64'd1);
    chk("ps_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    vecs[0] = '{beat: 48'hABCD_1234_5678, dmax: 0, w0: 32'h1234_5678, w1: 32'h0000_ABCD};
    vecs[1] = '{beat: 48'hABCD_1234_5678, dmax: 5, w0: 32'h1234_5678, w1: 32'h0000_ABCD};
    vecs[2] = '{beat: 48'hFFFF_FFFF_FFFF, dmax: 3, w0: 32'hFFFF_FFFF, w1: 32'h0000_FFFF};
    vecs[3] = '{beat: 48'h0000_0000_0001, dmax: 2, w0: 32'h0000_0001, w1: 32'h0000_0000};

    bus.s_data      = '0;
    bus.s_valid     = 1'b0;
    bus.wr_ack      = 1'b0;
    bus.ps_consumed = 1'b0;

    // Reset values and s_ready rising one edge after release.
    @(negedge clk);
    chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("rst_wr_req", 64'(bus.wr_req), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    #1 chk("release_s_ready_pre_edge", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    chk("release_s_ready", 64'(bus.s_ready), 64'd1);
    chk("release_busy", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 4; i++) begin
      accept_beat(vecs[i].beat);
      run_writes(vecs[i].dmax, vecs[i].w0, vecs[i].w1);
      finish_ps();
    end

    // Beat held through WAIT_PS is only taken on the edge after ps_consumed.
    accept_beat(48'hABCD_1234_5678);
    run_writes(0, 32'h1234_5678, 32'h0000_ABCD);
    bus.s_data  = 48'h0000_0000_0001;
    bus.s_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_not_accepted_wr_req", 64'(bus.wr_req), 64'd0);
    chk("held_not_accepted_s_ready", 64'(bus.s_ready), 64'd0);
    bus.ps_consumed = 1'b1;
    @(negedge clk);
    bus.ps_consumed = 1'b0;
    chk("held_at_p_s_ready", 64'(bus.s_ready), 64'd1);
    chk("held_at_p_wr_req", 64'(bus.wr_req), 64'd0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_data  = '1;
    chk("held_accepted_wr_req", 64'(bus.wr_req), 64'd1);
    chk("held_accepted_s_ready", 64'(bus.s_ready), 64'd0);
    run_writes(0, 32'h0000_0001, 32'h0000_0000);
    finish_ps();

    // ps_consumed during WRITE and FLAG, and wr_ack without wr_req, are ignored.
    accept_beat(48'h1111_2222_3333);
    bus.ps_consumed = 1'b1;
    @(negedge clk);
    bus.ps_consumed = 1'b0;
    chk("ps_in_write_wr_req", 64'(bus.wr_req), 64'd1);
    chk("ps_in_write_wr_addr", 64'(bus.wr_addr), 64'h10);
    bus.wr_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.wr_ack = 1'b0;
    bus.ps_consumed = 1'b1;
    @(negedge clk);
    bus.ps_consumed = 1'b0;
    chk("ps_in_flag_wr_req", 64'(bus.wr_req), 64'd1);
    chk("ps_in_flag_wr_addr", 64'(bus.wr_addr), 64'h12);
    chk("ps_in_flag_wr_data", 64'(bus.wr_data), 64'd1);
    bus.wr_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack_wr_req", 64'(bus.wr_req), 64'd0);
    @(negedge clk);
    bus.wr_ack = 1'b0;
    chk("stray_ack_wr_addr", 64'(bus.wr_addr), 64'h12);
    chk("ps_not_stored_s_ready", 64'(bus.s_ready), 64'd0);
    chk("ps_not_stored_busy", 64'(bus.busy), 64'd1);
    finish_ps();

    // Asynchronous reset while word 1 is pending, then a clean restart.
    accept_beat(48'hABCD_1234_5678);
    bus.wr_ack = 1'b1;
    @(negedge clk);
    bus.wr_ack = 1'b0;
    chk("mid_word1_wr_addr", 64'(bus.wr_addr), 64'h11);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wr_req", 64'(bus.wr_req), 64'd0);
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_s_ready", 64'(bus.s_ready), 64'd0);
    chk("async_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    accept_beat(48'h0000_0000_0001);
    run_writes(1, 32'h0000_0001, 32'h0000_0000);
    finish_ps();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
